id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly downstream of the decode control unit. It latches the decoded control bundle, register operands, immediate and PC+4 into the EX stage.
- It also detects load-use hazards and inserts bubbles.
- It honours branch/jump flushes from EX and hold requests from the memory side.
- Its outputs drive the EX-stage ALU mux, the forwarding logic and the EX/MEM register.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_AW, 5, register-address width
- ALUC_W, 3, ALU control width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_reg_write, id_reg_dst, id_mem_read, id_mem_write, id_branch, id_jump, id_alu_src, id_mem_to_reg  in  1 each  control bits from decode
- id_alu_control  in  ALUC_W  ALU op from decode
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc4  in  DATA_W  PC+4 of decode instruction
- id_rs, id_rt, id_rd  in  REG_AW  instruction register fields
- ex_flush  in  1  branch taken / jump resolved in EX
- mem_hold  in  1  downstream not ready; freeze EX
- stall  out  1  combinational; freeze PC and IF/ID
- ex_valid  out  1  EX slot holds a real instruction
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src, ex_mem_to_reg  out  1 each  registered control bits
- ex_alu_control  out  ALUC_W  registered ALU op
- ex_rs_data, ex_rt_data, ex_imm, ex_pc4  out  DATA_W  registered operands
- ex_rs, ex_rt  out  REG_AW  source addresses for forwarding
- ex_wr_addr  out  REG_AW  resolved destination register

Behaviour:
- Destination resolution, computed at capture:
  - wr_addr = (id_reg_dst | id_alu_src) ? id_rt : id_rd.
  - This gives ADDI/ANDI/LW → rt and R-type → rd.
- Source usage:
  - uses_rs = ~id_jump.
  - uses_rt = (~id_alu_src & ~id_jump) | id_mem_write. This covers R-type, BEQ and SW.
- Load-use condition (combinational):
  - load_use = id_valid & ex_valid & ex_mem_read & ex_reg_write & (ex_wr_addr != 0) & ((uses_rs & id_rs == ex_wr_addr) | (uses_rt & id_rt == ex_wr_addr)).
- Output: stall = (load_use | mem_hold) & ~ex_flush.
- Register update at each rising clk edge, first match wins:
  1. rst_n=0: all ex_* outputs = 0; ex_alu_control = 3'b100 (NOP).
  2. ex_flush=1: bubble, even if mem_hold=1.
  3. mem_hold=1: hold all ex_* unchanged.
  4. load_use=1: bubble. The decode instruction is retained upstream by stall and re-presented next cycle.
  5. Otherwise: capture all id_* fields and set ex_valid = id_valid.
- Bubble definition:
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump = 0.
  - ex_alu_control = NOP.
  - Data/address fields are don't-care and are cleared to 0.
- When id_valid=0 in normal capture, all control bits are captured as 0. No side effects can escape from an invalid slot.
- Latency: exactly 1 cycle from id_* to ex_*. A load-use hazard costs exactly 1 bubble, after which the dependent instruction issues.
- $0 destination never triggers a hazard.
- Back-to-back loads into the same register: each dependent instruction stalls only once.
- Reset mid-stall: stall drops the cycle after reset because ex_valid=0.
- No combinational path from id_* to ex_*. The stall path is combinational from ex_* and id_rs/id_rt/id_valid/mem_hold/ex_flush.

Optional Feature:
- PERF_CNT_EN defined: adds two outputs, bubble_cnt[15:0] and flush_cnt[15:0].
  - bubble_cnt increments on each load-use bubble cycle.
  - flush_cnt increments on each ex_flush cycle.
  - Both counters saturate at 16'hFFFF and clear on reset.
- PERF_CNT_EN undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random id_* → all ex_* = 0, ex_alu_control=3'b100, stall=0.
- Plain capture: ADDI (id_alu_src=1, id_rt=5, id_rd=9, id_imm=32'h10, alu_control=010) → next cycle ex_wr_addr=5, ex_imm=32'h10, ex_valid=1.
- Load-use:
  - Stimulus: LW $8 in EX, then ADD with id_rs=8 in ID.
  - Response: stall=1 for 1 cycle, EX holds a bubble (ex_valid=0), and ADD is captured on the following cycle with stall=0.
  - Repeat with a dependent ADDI on id_rt=8 → no stall, because rt is not a source for ADDI.
- $0 exemption: LW to $0 followed by ADD using rs=0 → stall=0.
- Flush priority: ex_flush=1 together with mem_hold=1 and load_use=1 → next cycle ex_valid=0, stall=0 during the flush cycle.
- Hold: mem_hold=1 for 3 cycles with changing id_* → ex_* constant and stall=1 throughout. With PERF_CNT_EN defined, the counters track bubbles and flushes exactly and saturate after 65535 events.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : id_ex_stage                                                 |
// | Purpose  : ID/EX pipeline register with load-use hazard detection,     |
// |            bubble insertion, EX flush and memory-side hold handling.   |
// | Options  : PERF_CNT_EN - adds saturating bubble/flush event counters   |
// |            (bubble_cnt, flush_cnt).                                     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // decode-side instruction bundle
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_reg_dst,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic              id_alu_src,
  input  logic              id_mem_to_reg,
  input  logic [ALUC_W-1:0] id_alu_control,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  // pipeline control
  input  logic              ex_flush,
  input  logic              mem_hold,
  output logic              stall,
  // EX-stage bundle
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic [ALUC_W-1:0] ex_alu_control,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_wr_addr
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam logic [ALUC_W-1:0] c_ALU_NOP = ALUC_W'(4);

  logic              r_valid;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_branch;
  logic              r_jump;
  logic              r_alu_src;
  logic              r_mem_to_reg;
  logic [ALUC_W-1:0] r_alu_control;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc4;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_wr_addr;

  logic [REG_AW-1:0] w_wr_addr;
  logic              w_uses_rs;
  logic              w_uses_rt;
  logic              w_rs_hit;
  logic              w_rt_hit;
  logic              w_load_use;
  logic              w_lu_bubble;
  logic              w_clear;

  // Destination select: immediate-form and loads write rt, R-type writes rd.
  assign w_wr_addr = (id_reg_dst | id_alu_src) ? id_rt : id_rd;

  // Jumps read no registers; stores read rt even though they use the immediate.
  assign w_uses_rs = ~id_jump;
  assign w_uses_rt = (~id_alu_src & ~id_jump) | id_mem_write;

  assign w_rs_hit  = w_uses_rs & (id_rs == r_wr_addr);
  assign w_rt_hit  = w_uses_rt & (id_rt == r_wr_addr);

  // A load in EX whose result is needed by the decode instruction; $0 never
  // carries a dependency.
  assign w_load_use = id_valid & r_valid & r_mem_read & r_reg_write &
                      (r_wr_addr != '0) & (w_rs_hit | w_rt_hit);

  // A flush kills the decode instruction anyway, so no freeze is needed then.
  assign stall = (w_load_use | mem_hold) & ~ex_flush;

  // Load-use bubbles only happen when the stage is neither flushed nor held.
  assign w_lu_bubble = ~ex_flush & ~mem_hold & w_load_use;

  // Reset, flush and load-use all leave an empty slot in EX.
  assign w_clear = ~rst_n | ex_flush | w_lu_bubble;

  // Pipeline register: clear to a bubble, hold, or capture the decode bundle.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_valid       <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_branch      <= 1'b0;
      r_jump        <= 1'b0;
      r_alu_src     <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_alu_control <= c_ALU_NOP;
      r_rs_data     <= '0;
      r_rt_data     <= '0;
      r_imm         <= '0;
      r_pc4         <= '0;
      r_rs          <= '0;
      r_rt          <= '0;
      r_wr_addr     <= '0;
    end else if (!mem_hold) begin
      // Control is gated by id_valid so an empty slot can have no side effects.
      r_valid       <= id_valid;
      r_reg_write   <= id_reg_write  & id_valid;
      r_mem_read    <= id_mem_read   & id_valid;
      r_mem_write   <= id_mem_write  & id_valid;
      r_branch      <= id_branch     & id_valid;
      r_jump        <= id_jump       & id_valid;
      r_alu_src     <= id_alu_src    & id_valid;
      r_mem_to_reg  <= id_mem_to_reg & id_valid;
      r_alu_control <= id_valid ? id_alu_control : c_ALU_NOP;
      r_rs_data     <= id_rs_data;
      r_rt_data     <= id_rt_data;
      r_imm         <= id_imm;
      r_pc4         <= id_pc4;
      r_rs          <= id_rs;
      r_rt          <= id_rt;
      r_wr_addr     <= w_wr_addr;
    end
  end

  assign ex_valid       = r_valid;
  assign ex_reg_write   = r_reg_write;
  assign ex_mem_read    = r_mem_read;
  assign ex_mem_write   = r_mem_write;
  assign ex_branch      = r_branch;
  assign ex_jump        = r_jump;
  assign ex_alu_src     = r_alu_src;
  assign ex_mem_to_reg  = r_mem_to_reg;
  assign ex_alu_control = r_alu_control;
  assign ex_rs_data     = r_rs_data;
  assign ex_rt_data     = r_rt_data;
  assign ex_imm         = r_imm;
  assign ex_pc4         = r_pc4;
  assign ex_rs          = r_rs;
  assign ex_rt          = r_rt;
  assign ex_wr_addr     = r_wr_addr;

`ifdef PERF_CNT_EN
  logic [15:0] r_bubble_cnt;
  logic [15:0] r_flush_cnt;

  // Saturating event counters for load-use bubbles and EX flushes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_lu_bubble && (r_bubble_cnt != 16'hFFFF))
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      if (ex_flush && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_id_ex_stage                                              |
// | Purpose  : Scoreboard testbench for id_ex_stage (PERF_CNT_EN aware).   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid, reg_write, reg_dst, mem_read, mem_write;
    logic        branch, jump, alu_src, mem_to_reg;
    logic [2:0]  alu;
    logic [31:0] rs_data, rt_data, imm, pc4;
    logic [4:0]  rs, rt, rd;
  } id_t;

  typedef struct packed {
    logic        valid, reg_write, mem_read, mem_write;
    logic        branch, jump, alu_src, mem_to_reg;
    logic [2:0]  alu;
    logic [31:0] rs_data, rt_data, imm, pc4;
    logic [4:0]  rs, rt, wr;
  } ex_t;

  localparam ex_t c_EMPTY = '{alu: 3'b100, default: '0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0, id_reg_write = 1'b0, id_reg_dst = 1'b0;
  logic        id_mem_read = 1'b0, id_mem_write = 1'b0, id_branch = 1'b0;
  logic        id_jump = 1'b0, id_alu_src = 1'b0, id_mem_to_reg = 1'b0;
  logic [2:0]  id_alu_control = 3'b100;
  logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0, id_pc4 = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        ex_flush = 1'b0, mem_hold = 1'b0;
  logic        stall;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_jump, ex_alu_src, ex_mem_to_reg;
  logic [2:0]  ex_alu_control;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_wr_addr;
`ifdef PERF_CNT_EN
  logic [15:0] bubble_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_reg_dst(id_reg_dst),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_jump(id_jump), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_control(id_alu_control), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_flush(ex_flush), .mem_hold(mem_hold), .stall(stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_control(ex_alu_control), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_wr_addr(ex_wr_addr)
`ifdef PERF_CNT_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  ex_t w_dut_ex;
  assign w_dut_ex = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
                     ex_jump, ex_alu_src, ex_mem_to_reg, ex_alu_control, ex_rs_data,
                     ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_wr_addr};

  int   total = 0;
  int   bad = 0;
  ex_t  sb[$];
  ex_t  m = c_EMPTY;
  bit   known = 1'b0;
  logic last_stall;
  int   e_bub = 0;
  int   e_fl = 0;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic id_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_t d;
    d = '0;
    d.valid   = 1'b1;
    d.alu     = 3'b010;
    d.rs      = rs;
    d.rt      = rt;
    d.rd      = rd;
    d.rs_data = $urandom;
    d.rt_data = $urandom;
    d.pc4     = $urandom;
    d.imm     = $urandom;
    return d;
  endfunction

  function automatic id_t f_addi(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
    id_t d;
    d = mk(rs, rt, 5'd9);
    d.reg_write = 1'b1;
    d.alu_src   = 1'b1;
    d.imm       = imm;
    return d;
  endfunction

  function automatic id_t f_lw(input logic [4:0] rs, input logic [4:0] rt);
    id_t d;
    d = mk(rs, rt, 5'd17);
    d.reg_write  = 1'b1;
    d.mem_read   = 1'b1;
    d.alu_src    = 1'b1;
    d.mem_to_reg = 1'b1;
    return d;
  endfunction

  function automatic id_t f_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_t d;
    d = mk(rs, rt, rd);
    d.reg_write = 1'b1;
    return d;
  endfunction

  // One clock: drive at negedge, check stall, predict and check the EX bundle.
  task automatic step(input id_t d, input bit rn, input bit fl, input bit hd);
    ex_t nx;
    bit  hz;
    bit  es;
    @(negedge clk);
    rst_n = rn; ex_flush = fl; mem_hold = hd;
    id_valid = d.valid; id_reg_write = d.reg_write; id_reg_dst = d.reg_dst;
    id_mem_read = d.mem_read; id_mem_write = d.mem_write; id_branch = d.branch;
    id_jump = d.jump; id_alu_src = d.alu_src; id_mem_to_reg = d.mem_to_reg;
    id_alu_control = d.alu; id_rs_data = d.rs_data; id_rt_data = d.rt_data;
    id_imm = d.imm; id_pc4 = d.pc4; id_rs = d.rs; id_rt = d.rt; id_rd = d.rd;
    #1;
    hz = 1'b0;
    if (m.valid && m.mem_read && m.reg_write && (m.wr != 5'd0) && d.valid) begin
      if (!d.jump && (d.rs == m.wr)) hz = 1'b1;
      if ((d.mem_write || (!d.alu_src && !d.jump)) && (d.rt == m.wr)) hz = 1'b1;
    end
    es = (hz || hd) && !fl;
    last_stall = stall;
    if (known) chk("stall", stall, es);
    if (!rn || fl)    nx = c_EMPTY;
    else if (hd)      nx = m;
    else if (hz)      nx = c_EMPTY;
    else begin
      nx.valid      = d.valid;
      nx.reg_write  = d.reg_write & d.valid;
      nx.mem_read   = d.mem_read & d.valid;
      nx.mem_write  = d.mem_write & d.valid;
      nx.branch     = d.branch & d.valid;
      nx.jump       = d.jump & d.valid;
      nx.alu_src    = d.alu_src & d.valid;
      nx.mem_to_reg = d.mem_to_reg & d.valid;
      nx.alu        = d.valid ? d.alu : 3'b100;
      nx.rs_data    = d.rs_data;
      nx.rt_data    = d.rt_data;
      nx.imm        = d.imm;
      nx.pc4        = d.pc4;
      nx.rs         = d.rs;
      nx.rt         = d.rt;
      nx.wr         = (d.reg_dst || d.alu_src) ? d.rt : d.rd;
    end
    if (!rn) begin
      e_bub = 0; e_fl = 0;
    end else if (fl) begin
      if (e_fl < 65535) e_fl++;
    end else if (!hd && hz) begin
      if (e_bub < 65535) e_bub++;
    end
    sb.push_back(nx);
    m = nx;
    @(posedge clk);
    #1;
    chk("sb_depth", sb.size(), 1);
    if (sb.size() != 0) chk("ex_bundle", w_dut_ex, sb.pop_front());
    known = 1'b1;
  endtask

  initial begin
    id_t  d;
    id_t  add8;
    id_t  nop;
    logic [31:0] held_imm;
    nop = '0;
    nop.alu = 3'b100;

    // reset with random decode contents
    step(f_add(5'($urandom), 5'($urandom), 5'($urandom)), 1'b0, 1'b0, 1'b0);
    step(f_lw(5'($urandom), 5'($urandom)), 1'b0, 1'b0, 1'b0);
    chk("rst_alu", ex_alu_control, 3'b100);
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_stall", stall, 1'b0);

    // plain ADDI capture
    step(f_addi(5'd1, 5'd5, 32'h10), 1'b1, 1'b0, 1'b0);
    chk("addi_wr", ex_wr_addr, 5'd5);
    chk("addi_imm", ex_imm, 32'h10);
    chk("addi_valid", ex_valid, 1'b1);

    // load-use on rs: one bubble, then the ADD issues
    step(f_lw(5'd2, 5'd8), 1'b1, 1'b0, 1'b0);
    add8 = f_add(5'd8, 5'd3, 5'd10);
    step(add8, 1'b1, 1'b0, 1'b0);
    chk("lu_stall", last_stall, 1'b1);
    chk("lu_bubble", ex_valid, 1'b0);
    step(add8, 1'b1, 1'b0, 1'b0);
    chk("lu_release", last_stall, 1'b0);
    chk("lu_add_wr", ex_wr_addr, 5'd10);

    // ADDI reading rt=8 after a load into $8 is not a dependency
    step(f_lw(5'd2, 5'd8), 1'b1, 1'b0, 1'b0);
    step(f_addi(5'd4, 5'd8, 32'h7), 1'b1, 1'b0, 1'b0);
    chk("addi_rt_nostall", last_stall, 1'b0);

    // load into $0 never stalls
    step(f_lw(5'd2, 5'd0), 1'b1, 1'b0, 1'b0);
    step(f_add(5'd0, 5'd0, 5'd11), 1'b1, 1'b0, 1'b0);
    chk("zero_nostall", last_stall, 1'b0);

    // back-to-back loads into $7: each dependent stalls once
    step(f_lw(5'd1, 5'd7), 1'b1, 1'b0, 1'b0);
    d = f_lw(5'd7, 5'd7);
    step(d, 1'b1, 1'b0, 1'b0);
    chk("b2b_stall1", last_stall, 1'b1);
    step(d, 1'b1, 1'b0, 1'b0);
    chk("b2b_go1", last_stall, 1'b0);
    d = f_add(5'd7, 5'd1, 5'd12);
    step(d, 1'b1, 1'b0, 1'b0);
    chk("b2b_stall2", last_stall, 1'b1);
    step(d, 1'b1, 1'b0, 1'b0);
    chk("b2b_go2", last_stall, 1'b0);

    // flush outranks hold and load-use
    step(f_lw(5'd1, 5'd6), 1'b1, 1'b0, 1'b0);
    step(f_add(5'd6, 5'd6, 5'd13), 1'b1, 1'b1, 1'b1);
    chk("flush_stall", last_stall, 1'b0);
    chk("flush_valid", ex_valid, 1'b0);

    // memory hold freezes EX for three cycles
    step(f_addi(5'd3, 5'd14, 32'h55), 1'b1, 1'b0, 1'b0);
    held_imm = ex_imm;
    for (int i = 0; i < 3; i++) begin
      step(f_add(5'($urandom), 5'($urandom), 5'($urandom)), 1'b1, 1'b0, 1'b1);
      chk("hold_stall", last_stall, 1'b1);
      chk("hold_imm", ex_imm, held_imm);
    end

    // invalid slot carries no side effects
    d = f_lw(5'd1, 5'd2);
    d.valid = 1'b0;
    d.alu = 3'b100;
    step(d, 1'b1, 1'b0, 1'b0);
    chk("inv_ctrl", {ex_valid, ex_reg_write, ex_mem_read}, 3'b000);

    // reset while a load-use stall is pending
    step(f_lw(5'd1, 5'd8), 1'b1, 1'b0, 1'b0);
    step(add8, 1'b0, 1'b0, 1'b0);
    step(add8, 1'b1, 1'b0, 1'b0);
    chk("rst_stall_drop", last_stall, 1'b0);

    // random traffic over a small register window
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 6))
        0: d = f_addi(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom);
        1, 2: d = f_lw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        3: d = f_add(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        4: begin
          d = f_lw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
          d.reg_write = 1'b0; d.mem_read = 1'b0; d.mem_to_reg = 1'b0; d.mem_write = 1'b1;
        end
        5: begin
          d = f_add(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'd0);
          d.reg_write = 1'b0; d.branch = 1'b1;
        end
        default: begin
          d = f_add(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'd0);
          d.reg_write = 1'b0; d.jump = 1'b1;
        end
      endcase
      d.reg_dst = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) begin
        d.valid = 1'b0;
        d.alu = 3'b100;
      end
      step(d, 1'b1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

`ifdef PERF_CNT_EN
    chk("bubble_cnt", bubble_cnt, 16'(e_bub));
    chk("flush_cnt", flush_cnt, 16'(e_fl));
    @(negedge clk);
    ex_flush = 1'b1;
    mem_hold = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    chk("flush_sat", flush_cnt, 16'hFFFF);
    step(nop, 1'b0, 1'b0, 1'b0);
    chk("cnt_clear", {bubble_cnt, flush_cnt}, 32'h0);
`endif

    step(nop, 1'b1, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
